// File: rtl/multdiv_controller.sv
// multdiv_controller: sequences the iterative multiply/divide units for the CPU.
// Accepts a one-cycle ctrl_MULT/ctrl_DIV request, latches the operands, releases the
// selected unit from restart, waits for its ready and returns a registered result
// with a one-cycle data_resultRDY pulse. Divide-by-zero and a hung unit both give
// result 0 with an exception. A new request always aborts the operation in flight.
// Ports:
//   clk, rst (sync, active-low)        clock and reset
//   ctrl_MULT, ctrl_DIV                start pulses (MULT wins if both are high)
//   data_operandA/B                    operands, sampled on the request cycle
//   op_a, op_b                         latched operands to both units
//   mult_rst, div_rst                  active-high restart of each unit
//   mult_ready/exception/result        multiplier handshake
//   div_ready/exception/quotient       divider handshake
//   data_result, data_exception        registered result and exception
//   data_resultRDY                     one-cycle result-valid pulse
//   busy                               high while RUN or DONE
module multdiv_controller #(
    parameter int MAX_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        mult_rst,
    output logic        div_rst,
    input  logic        mult_ready,
    input  logic        mult_exception,
    input  logic [31:0] mult_result,
    input  logic        div_ready,
    input  logic        div_exception,
    input  logic [31:0] div_quotient,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     r_state;
    logic       r_is_div;
    logic [5:0] r_cnt;
    logic       w_req;
    logic       w_div_req;
    logic       w_ready;
    logic       w_last;
    assign w_req     = ctrl_MULT | ctrl_DIV;
    assign w_div_req = ctrl_DIV & ~ctrl_MULT;
    // Only the selected unit's ready counts; the idle unit is held in restart anyway.
    assign w_ready   = r_is_div ? div_ready : mult_ready;
    assign w_last    = r_cnt == 6'(MAX_CYCLES - 1);
    // Units run only while RUN selects them, so an abort or idle period clears them.
    assign mult_rst       = !(r_state == RUN && !r_is_div);
    assign div_rst        = !(r_state == RUN && r_is_div);
    assign busy           = r_state != IDLE;
    assign data_resultRDY = r_state == DONE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_is_div       <= 1'b0;
            r_cnt          <= '0;
            op_a           <= '0;
            op_b           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (w_req) begin
            // A request overrides whatever is in flight, including a same-cycle ready.
            op_a     <= data_operandA;
            op_b     <= data_operandB;
            r_is_div <= w_div_req;
            r_cnt    <= '0;
            if (w_div_req && data_operandB == '0) begin
                r_state        <= DONE;
                data_result    <= '0;
                data_exception <= 1'b1;
            end else begin
                r_state <= RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_last) r_cnt <= r_cnt + 6'd1;
                    if (w_ready) begin
                        data_result    <= r_is_div ? div_quotient : mult_result;
                        data_exception <= r_is_div ? div_exception : mult_exception;
                        r_state        <= DONE;
                    end else if (w_last) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                        r_state        <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller: scoreboard bench for multdiv_controller with simple unit models.
module tb_multdiv_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] op_a, op_b, data_result;
    logic        mult_rst, div_rst, data_exception, data_resultRDY, busy;
    logic        mult_ready, div_ready;
    logic        mult_exception = 1'b0;
    logic        div_exception = 1'b0;
    logic [31:0] mult_result, div_quotient;
    int          mult_lat = 17;
    int          div_lat = 34;
    bit          mult_en = 1'b1;
    bit          div_en = 1'b1;
    bit          stray_div = 1'b0;
    int          mcnt = 0;
    int          dcnt = 0;
    int          ncyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] sb[$];
    logic [32:0] exp_v;

    multdiv_controller #(.MAX_CYCLES(40)) dut (
        .clk(clk), .rst(rst), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .op_a(op_a), .op_b(op_b), .mult_rst(mult_rst), .div_rst(div_rst),
        .mult_ready(mult_ready), .mult_exception(mult_exception), .mult_result(mult_result),
        .div_ready(div_ready), .div_exception(div_exception), .div_quotient(div_quotient),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) ncyc++;

    // Unit models: count cycles out of restart, assert ready on the last latency cycle.
    always @(posedge clk) begin
        mcnt <= mult_rst ? 0 : mcnt + 1;
        dcnt <= div_rst ? 0 : dcnt + 1;
    end
    assign mult_ready   = mult_en && !mult_rst && mcnt == mult_lat - 1;
    assign div_ready    = (div_en && !div_rst && dcnt == div_lat - 1) || stray_div;
    assign mult_result  = op_a * op_b;
    assign div_quotient = (op_b == 0) ? 32'd0 : op_a / op_b;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, output int t0);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        t0 = ncyc;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(input int bound, output int at, output bit busy_all,
                            output bit mrst_all, output bit drst_all);
        at = -1;
        busy_all = 1'b1;
        mrst_all = 1'b1;
        drst_all = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (!busy) busy_all = 1'b0;
            if (!mult_rst) mrst_all = 1'b0;
            if (!div_rst) drst_all = 1'b0;
            if (data_resultRDY) begin
                at = ncyc;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if ({busy, data_resultRDY, data_exception, mult_rst, div_rst} !== 5'b00011) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/rdy/exc/mrst/drst=%b expected 00011",
                     {busy, data_resultRDY, data_exception, mult_rst, div_rst});
        end
        vectors++;
        if ({op_a, op_b, data_result} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data: op_a=%h op_b=%h result=%h expected all 0", op_a, op_b, data_result);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_div();
        int t0, at;
        bit b_all, m_all, d_all;
        tick();
        sb.push_back({32'd14, 1'b0});
        issue(1'b0, 1'b1, 32'd100, 32'd7, t0);
        vectors++;
        if ({op_a, op_b, div_rst, mult_rst} !== {32'd100, 32'd7, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL div_start: op_a=%0d op_b=%0d drst=%b mrst=%b expected 100 7 0 1",
                     op_a, op_b, div_rst, mult_rst);
        end
        wait_rdy(60, at, b_all, m_all, d_all);
        vectors++;
        if (at - t0 !== 35 || !b_all || !m_all) begin
            miscompares++;
            $display("FAIL div_timing: pulse at t+%0d busy_all=%b mrst_all=%b expected t+35 1 1",
                     at - t0, b_all, m_all);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL div_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
        tick();
        vectors++;
        if ({busy, data_resultRDY, data_result} !== {1'b0, 1'b0, 32'd14}) begin
            miscompares++;
            $display("FAIL div_after: busy=%b rdy=%b result=%0d expected 0 0 14",
                     busy, data_resultRDY, data_result);
        end
    endtask

    task automatic test_div_zero();
        int t0;
        tick();
        sb.push_back({32'd0, 1'b1});
        issue(1'b0, 1'b1, 32'd5, 32'd0, t0);
        vectors++;
        if ({data_resultRDY, div_rst, mult_rst} !== 3'b111) begin
            miscompares++;
            $display("FAIL div0_pulse: rdy=%b drst=%b mrst=%b expected 1 1 1",
                     data_resultRDY, div_rst, mult_rst);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL div0_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
        tick();
        vectors++;
        if ({busy, data_resultRDY, div_rst} !== 3'b001) begin
            miscompares++;
            $display("FAIL div0_after: busy=%b rdy=%b drst=%b expected 0 0 1", busy, data_resultRDY, div_rst);
        end
    endtask

    task automatic test_mult();
        int t0, at;
        bit b_all, m_all, d_all;
        tick();
        sb.push_back({32'hFFFF_FFF1, 1'b0});
        issue(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, t0);
        wait_rdy(60, at, b_all, m_all, d_all);
        vectors++;
        if (at - t0 !== 18 || !d_all) begin
            miscompares++;
            $display("FAIL mult_timing: pulse at t+%0d drst_all=%b expected t+18 1", at - t0, d_all);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL mult_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
    endtask

    task automatic test_abort();
        int t0, t1, at;
        bit b_all, m_all, d_all;
        bit early;
        early = 1'b0;
        tick();
        issue(1'b0, 1'b1, 32'd1000, 32'd3, t0);
        while (ncyc < t0 + 10) begin
            if (data_resultRDY) early = 1'b1;
            tick();
        end
        sb.push_back({32'd42, 1'b0});
        stray_div = 1'b1;
        issue(1'b1, 1'b0, 32'd6, 32'd7, t1);
        vectors++;
        if ({div_rst, mult_rst, data_resultRDY, early} !== 4'b1000) begin
            miscompares++;
            $display("FAIL abort_switch: drst=%b mrst=%b rdy=%b early_pulse=%b expected 1 0 0 0",
                     div_rst, mult_rst, data_resultRDY, early);
        end
        wait_rdy(60, at, b_all, m_all, d_all);
        stray_div = 1'b0;
        vectors++;
        if (at - t1 !== 18 || !d_all) begin
            miscompares++;
            $display("FAIL abort_timing: pulse at t1+%0d drst_all=%b expected t1+18 1", at - t1, d_all);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL abort_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
    endtask

    task automatic test_timeout();
        int t0, at;
        bit b_all, m_all, d_all;
        mult_en = 1'b0;
        tick();
        sb.push_back({32'd0, 1'b1});
        issue(1'b1, 1'b0, 32'd2, 32'd3, t0);
        wait_rdy(80, at, b_all, m_all, d_all);
        mult_en = 1'b1;
        vectors++;
        if (at - t0 !== 41 || !b_all) begin
            miscompares++;
            $display("FAIL timeout_timing: pulse at t+%0d busy_all=%b expected t+41 1", at - t0, b_all);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL timeout_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, at;
        bit b_all, m_all, d_all;
        tick();
        sb.push_back({32'd0, 1'b1});
        sb.push_back({32'd42, 1'b0});
        issue(1'b0, 1'b1, 32'd100, 32'd0, t0);
        vectors++;
        if (data_resultRDY !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_pulse: rdy=%b expected 1", data_resultRDY);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_first_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
        issue(1'b1, 1'b0, 32'd6, 32'd7, t1);
        vectors++;
        if ({busy, mult_rst, data_resultRDY} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_run: busy=%b mrst=%b rdy=%b expected 1 0 0", busy, mult_rst, data_resultRDY);
        end
        wait_rdy(60, at, b_all, m_all, d_all);
        vectors++;
        if (at - t1 !== 18) begin
            miscompares++;
            $display("FAIL b2b_timing: pulse at t1+%0d expected t1+18", at - t1);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_second_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int t0, at;
        bit b_all, m_all, d_all;
        bit stray;
        stray = 1'b0;
        tick();
        issue(1'b0, 1'b1, 32'd50, 32'd5, t0);
        while (ncyc < t0 + 5) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({busy, data_resultRDY, data_exception, mult_rst, div_rst} !== 5'b00011) begin
            miscompares++;
            $display("FAIL midrst_ctrl: busy/rdy/exc/mrst/drst=%b expected 00011",
                     {busy, data_resultRDY, data_exception, mult_rst, div_rst});
        end
        vectors++;
        if ({op_a, op_b, data_result} !== 96'd0) begin
            miscompares++;
            $display("FAIL midrst_data: op_a=%h op_b=%h result=%h expected all 0", op_a, op_b, data_result);
        end
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_resultRDY || busy) stray = 1'b1;
        end
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet: activity after reset=%b expected 0", stray);
        end
        sb.push_back({32'd3, 1'b0});
        issue(1'b0, 1'b1, 32'd9, 32'd3, t0);
        wait_rdy(60, at, b_all, m_all, d_all);
        vectors++;
        if (at - t0 !== 35) begin
            miscompares++;
            $display("FAIL midrst_div_timing: pulse at t+%0d expected t+35", at - t0);
        end
        exp_v = sb.pop_front();
        vectors++;
        if ({data_result, data_exception} !== exp_v) begin
            miscompares++;
            $display("FAIL midrst_div_result: got %h/%b expected %h/%b", data_result, data_exception,
                     exp_v[32:1], exp_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_div_zero();
        test_mult();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
